axi_clint_timer: RTL and testbench

Memory-mapped machine timer (CLINT subset) that produces the `time_i` / `time_irq_i` inputs of the single-core AXI wrapper. It also optionally produces the software interrupt. It hangs off the peripheral side of the core's AXI4 bus as a slave, so the core programs `mtimecmp` and `mtime` through its own uncached accesses. It holds a free-running 64-bit `mtime` counter with a configurable prescaler and raises a level timer interrupt when `mtime >= mtimecmp`.

---
 rtl/clint_pkg.sv | 12 +
 rtl/clint_tick_gen.sv | 24 ++
 rtl/axi_clint_timer.sv | 198 +++++++++++++++++++
 tb/tb_axi_clint_timer.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/clint_pkg.sv
// clint_pkg: register offsets, AXI response codes and FSM state types for axi_clint_timer
package clint_pkg;
    localparam logic [15:0] CLINT_MSIP_OFF     = 16'h0000;
    localparam logic [15:0] CLINT_MTIMECMP_OFF = 16'h4000;
    localparam logic [15:0] CLINT_MTIME_OFF    = 16'hBFF8;
    localparam logic [63:0] MTIMECMP_RST       = '1;
    localparam logic [1:0]  RESP_OKAY          = 2'b00;
    localparam logic [1:0]  RESP_SLVERR        = 2'b10;
    localparam logic [1:0]  RESP_DECERR        = 2'b11;
    typedef enum logic [2:0] {W_IDLE, W_WAIT_W, W_WAIT_AW, W_DATA, W_RESP} clint_wr_state_t;
    typedef enum logic {R_IDLE, R_RESP} clint_rd_state_t;
endpackage

// File: rtl/clint_tick_gen.sv
// clint_tick_gen: prescaler that pulses tick_o once every PRESCALE clock cycles
module clint_tick_gen #(
    parameter int PRESCALE = 1
) (
    input  logic clk_i,
    input  logic rstn_i,
    output logic tick_o
);
    if (PRESCALE < 1) begin : g_chk
        $error("PRESCALE must be >= 1");
    end
    if (PRESCALE == 1) begin : g_always
        logic unused_in;
        assign unused_in = clk_i ^ rstn_i;
        assign tick_o = 1'b1;
    end else begin : g_cnt
        localparam int CW = $clog2(PRESCALE);
        logic [CW-1:0] cnt;
        assign tick_o = cnt == CW'(PRESCALE - 1);
        always_ff @(posedge clk_i or negedge rstn_i)
            if (!rstn_i) cnt <= '0;
            else cnt <= tick_o ? '0 : cnt + CW'(1);
    end
endmodule

// File: rtl/axi_clint_timer.sv
// axi_clint_timer: AXI4 slave CLINT subset (mtime/mtimecmp, optional msip) driving timer/soft IRQs.
// Define CLINT_MSIP_EN to implement msip at offset 0x0000; otherwise that offset decodes as unmapped.
module axi_clint_timer
    import clint_pkg::*;
#(
    parameter int AXI_ADDR_WIDTH = 64,
    parameter int AXI_DATA_WIDTH = 64,
    parameter int AXI_ID_WIDTH   = 6,
    parameter int AXI_USER_WIDTH = 11,
    parameter int PRESCALE       = 1
) (
    input  logic                        clk_i,
    input  logic                        rstn_i,
    input  logic [AXI_ID_WIDTH-1:0]     axi_awid,
    input  logic [AXI_ADDR_WIDTH-1:0]   axi_awaddr,
    input  logic [7:0]                  axi_awlen,
    input  logic                        axi_awvalid,
    output logic                        axi_awready,
    input  logic [AXI_DATA_WIDTH-1:0]   axi_wdata,
    input  logic [AXI_DATA_WIDTH/8-1:0] axi_wstrb,
    input  logic                        axi_wlast,
    input  logic                        axi_wvalid,
    output logic                        axi_wready,
    output logic [AXI_ID_WIDTH-1:0]     axi_bid,
    output logic [1:0]                  axi_bresp,
    output logic [AXI_USER_WIDTH-1:0]   axi_buser,
    output logic                        axi_bvalid,
    input  logic                        axi_bready,
    input  logic [AXI_ID_WIDTH-1:0]     axi_arid,
    input  logic [AXI_ADDR_WIDTH-1:0]   axi_araddr,
    input  logic [7:0]                  axi_arlen,
    input  logic                        axi_arvalid,
    output logic                        axi_arready,
    output logic [AXI_ID_WIDTH-1:0]     axi_rid,
    output logic [AXI_DATA_WIDTH-1:0]   axi_rdata,
    output logic [1:0]                  axi_rresp,
    output logic                        axi_rlast,
    output logic [AXI_USER_WIDTH-1:0]   axi_ruser,
    output logic                        axi_rvalid,
    input  logic                        axi_rready,
    output logic [63:0]                 time_o,
    output logic                        time_irq_o,
    output logic                        soft_irq_o
);
    if (AXI_DATA_WIDTH != 64) begin : g_dw_chk
        $error("axi_clint_timer supports only AXI_DATA_WIDTH == 64");
    end
`ifdef CLINT_MSIP_EN
    localparam logic MSIP_EN = 1'b1;
`else
    localparam logic MSIP_EN = 1'b0;
`endif

    clint_wr_state_t         wst;
    clint_rd_state_t         rst_q;
    logic [AXI_ID_WIDTH-1:0] aw_id;
    logic [12:0]             aw_sel, wr_sel, rd_sel;
    logic [63:0]             w_data, wr_data, rd_val;
    logic [7:0]              w_strb, wr_strb, r_len, r_cnt;
    logic [63:0]             mtime, mtimecmp, mtime_inc, mtime_nxt, cmp_nxt;
    logic                    msip, msip_nxt, time_irq, soft_irq, tick, wr_go, aw_burst;
    logic                    unused_addr;

    function automatic logic mapped(input logic [12:0] sel);
        return sel == CLINT_MTIME_OFF[15:3] || sel == CLINT_MTIMECMP_OFF[15:3] ||
               (MSIP_EN && sel == CLINT_MSIP_OFF[15:3]);
    endfunction

    clint_tick_gen #(.PRESCALE(PRESCALE)) u_tick (.clk_i(clk_i), .rstn_i(rstn_i), .tick_o(tick));

    assign unused_addr = ^{axi_awaddr[AXI_ADDR_WIDTH-1:16], axi_awaddr[2:0],
                           axi_araddr[AXI_ADDR_WIDTH-1:16], axi_araddr[2:0]};
    assign axi_awready = wst == W_IDLE || wst == W_WAIT_AW;
    assign axi_wready  = wst == W_IDLE || wst == W_WAIT_W || wst == W_DATA;
    assign axi_bvalid  = wst == W_RESP;
    assign axi_bid     = aw_id;
    assign axi_buser   = '0;
    assign axi_arready = rst_q == R_IDLE;
    assign axi_rvalid  = rst_q == R_RESP;
    assign axi_rlast   = r_cnt == r_len;
    assign axi_ruser   = '0;
    assign aw_burst    = axi_awvalid && axi_awready && axi_awlen != 8'd0;
    assign time_o      = mtime;
    assign time_irq_o  = time_irq;
    assign soft_irq_o  = MSIP_EN & soft_irq;

    // A register write fires on whichever edge completes the AW/W pair of a single-beat transfer
    always_comb begin
        wr_go   = 1'b0;
        wr_sel  = aw_sel;
        wr_data = w_data;
        wr_strb = w_strb;
        if (wst == W_IDLE && axi_awvalid && axi_wvalid && axi_awlen == 8'd0) begin
            wr_go   = 1'b1;
            wr_sel  = axi_awaddr[15:3];
            wr_data = axi_wdata;
            wr_strb = axi_wstrb;
        end else if (wst == W_WAIT_W && axi_wvalid) begin
            wr_go   = 1'b1;
            wr_data = axi_wdata;
            wr_strb = axi_wstrb;
        end else if (wst == W_WAIT_AW && axi_awvalid && axi_awlen == 8'd0) begin
            wr_go   = 1'b1;
            wr_sel  = axi_awaddr[15:3];
        end
    end

    // Written byte lanes override; unwritten mtime lanes still advance with the tick
    always_comb begin
        mtime_inc = mtime + {63'd0, tick};
        for (int i = 0; i < 8; i++) begin
            mtime_nxt[i*8+:8] = wr_go && wr_sel == CLINT_MTIME_OFF[15:3] && wr_strb[i] ?
                                wr_data[i*8+:8] : mtime_inc[i*8+:8];
            cmp_nxt[i*8+:8]   = wr_go && wr_sel == CLINT_MTIMECMP_OFF[15:3] && wr_strb[i] ?
                                wr_data[i*8+:8] : mtimecmp[i*8+:8];
        end
        msip_nxt = MSIP_EN && wr_go && wr_sel == CLINT_MSIP_OFF[15:3] && wr_strb[0] ? wr_data[0] : msip;
    end

    always_comb begin
        rd_sel = axi_araddr[15:3];
        rd_val = rd_sel == CLINT_MTIME_OFF[15:3]    ? mtime :
                 rd_sel == CLINT_MTIMECMP_OFF[15:3] ? mtimecmp :
                 MSIP_EN && rd_sel == CLINT_MSIP_OFF[15:3] ? {63'd0, msip} : 64'd0;
    end

    always_ff @(posedge clk_i or negedge rstn_i)
        if (!rstn_i) begin
            mtime    <= '0;
            mtimecmp <= MTIMECMP_RST;
            msip     <= 1'b0;
            time_irq <= 1'b0;
            soft_irq <= 1'b0;
        end else begin
            mtime    <= mtime_nxt;
            mtimecmp <= cmp_nxt;
            msip     <= msip_nxt;
            time_irq <= mtime >= mtimecmp;
            soft_irq <= msip;
        end

    always_ff @(posedge clk_i or negedge rstn_i)
        if (!rstn_i) begin
            wst       <= W_IDLE;
            aw_id     <= '0;
            aw_sel    <= '0;
            w_data    <= '0;
            w_strb    <= '0;
            axi_bresp <= RESP_OKAY;
        end else begin
            if (wr_go) axi_bresp <= mapped(wr_sel) ? RESP_OKAY : RESP_DECERR;
            else if (aw_burst) axi_bresp <= RESP_SLVERR;
            case (wst)
                W_IDLE:
                    if (axi_awvalid) begin
                        aw_id  <= axi_awid;
                        aw_sel <= axi_awaddr[15:3];
                        wst    <= axi_awlen != 8'd0 ? W_DATA : axi_wvalid ? W_RESP : W_WAIT_W;
                    end else if (axi_wvalid) begin
                        w_data <= axi_wdata;
                        w_strb <= axi_wstrb;
                        wst    <= W_WAIT_AW;
                    end
                W_WAIT_W:  if (axi_wvalid) wst <= W_RESP;
                W_WAIT_AW:
                    if (axi_awvalid) begin
                        aw_id <= axi_awid;
                        wst   <= axi_awlen != 8'd0 ? W_DATA : W_RESP;
                    end
                W_DATA:    if (axi_wvalid && axi_wlast) wst <= W_RESP;
                W_RESP:    if (axi_bready) wst <= W_IDLE;
                default:   wst <= W_IDLE;
            endcase
        end

    // Read data is sampled when AR is accepted; bursts return zero SLVERR beats
    always_ff @(posedge clk_i or negedge rstn_i)
        if (!rstn_i) begin
            rst_q     <= R_IDLE;
            axi_rid   <= '0;
            axi_rdata <= '0;
            axi_rresp <= RESP_OKAY;
            r_len     <= '0;
            r_cnt     <= '0;
        end else if (rst_q == R_IDLE) begin
            if (axi_arvalid) begin
                rst_q     <= R_RESP;
                axi_rid   <= axi_arid;
                r_len     <= axi_arlen;
                r_cnt     <= '0;
                axi_rdata <= axi_arlen != 8'd0 ? 64'd0 : rd_val;
                axi_rresp <= axi_arlen != 8'd0 ? RESP_SLVERR : mapped(rd_sel) ? RESP_OKAY : RESP_DECERR;
            end
        end else if (axi_rready) begin
            r_cnt <= r_cnt + 8'd1;
            if (axi_rlast) rst_q <= R_IDLE;
        end
endmodule

// File: tb/tb_axi_clint_timer.sv
// tb_axi_clint_timer: directed stimulus with B/R scoreboard queues checked by independent monitors
module tb_axi_clint_timer;
    import clint_pkg::*;
    localparam int IDW = 4;
    localparam int UW  = 11;

    logic clk = 1'b0, rstn = 1'b0;
    always #5 clk = ~clk;

    logic [IDW-1:0] axi_awid = '0, axi_arid = '0, axi_bid, axi_rid;
    logic [63:0]    axi_awaddr = '0, axi_araddr = '0, axi_wdata = '0, axi_rdata, time_o;
    logic [7:0]     axi_awlen = '0, axi_arlen = '0, axi_wstrb = '0;
    logic           axi_awvalid = 1'b0, axi_wvalid = 1'b0, axi_wlast = 1'b1, axi_arvalid = 1'b0;
    logic           axi_bready = 1'b1, axi_rready = 1'b1;
    logic           axi_awready, axi_wready, axi_bvalid, axi_arready, axi_rvalid, axi_rlast;
    logic [1:0]     axi_bresp, axi_rresp;
    logic [UW-1:0]  axi_buser, axi_ruser;
    logic           time_irq_o, soft_irq_o;

    axi_clint_timer #(.AXI_ID_WIDTH(IDW), .AXI_USER_WIDTH(UW), .PRESCALE(1)) dut (
        .clk_i(clk), .rstn_i(rstn),
        .axi_awid(axi_awid), .axi_awaddr(axi_awaddr), .axi_awlen(axi_awlen),
        .axi_awvalid(axi_awvalid), .axi_awready(axi_awready),
        .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb), .axi_wlast(axi_wlast),
        .axi_wvalid(axi_wvalid), .axi_wready(axi_wready),
        .axi_bid(axi_bid), .axi_bresp(axi_bresp), .axi_buser(axi_buser),
        .axi_bvalid(axi_bvalid), .axi_bready(axi_bready),
        .axi_arid(axi_arid), .axi_araddr(axi_araddr), .axi_arlen(axi_arlen),
        .axi_arvalid(axi_arvalid), .axi_arready(axi_arready),
        .axi_rid(axi_rid), .axi_rdata(axi_rdata), .axi_rresp(axi_rresp), .axi_rlast(axi_rlast),
        .axi_ruser(axi_ruser), .axi_rvalid(axi_rvalid), .axi_rready(axi_rready),
        .time_o(time_o), .time_irq_o(time_irq_o), .soft_irq_o(soft_irq_o)
    );

    typedef struct packed {logic [IDW-1:0] id; logic [1:0] resp;} b_t;
    typedef struct packed {logic [IDW-1:0] id; logic [63:0] data; logic [1:0] resp; logic last;} r_t;
    b_t bq[$];
    r_t rq[$];
    b_t be;
    r_t re;
    int tests = 0, fails = 0;
    logic [IDW-1:0] tid = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic timeout(input string name);
        tests++;
        fails++;
        $display("FAIL %s: timed out at %0t", name, $time);
    endtask

    always @(negedge clk)
        if (rstn && axi_bvalid && axi_bready) begin
            if (bq.size() == 0) timeout("b_unexpected");
            else begin
                be = bq.pop_front();
                chk("bresp", 64'(axi_bresp), 64'(be.resp));
                chk("bid", 64'(axi_bid), 64'(be.id));
                chk("buser", 64'(axi_buser), 64'd0);
            end
        end

    always @(negedge clk)
        if (rstn && axi_rvalid && axi_rready) begin
            if (rq.size() == 0) timeout("r_unexpected");
            else begin
                re = rq.pop_front();
                chk("rdata", axi_rdata, re.data);
                chk("rresp", 64'(axi_rresp), 64'(re.resp));
                chk("rlast", 64'(axi_rlast), 64'(re.last));
                chk("rid", 64'(axi_rid), 64'(re.id));
            end
        end

    task automatic wr(input logic [15:0] off, input logic [63:0] d, input logic [7:0] s,
                      input logic [1:0] resp, input int lead);
        int n = 0;
        while (!(axi_awready && axi_wready) && n < 20) begin
            @(posedge clk); #1; n++;
        end
        if (n == 20) timeout("wr_ready");
        bq.push_back('{id: tid, resp: resp});
        axi_awid = tid; axi_awaddr = {48'hA5A5_0000_0000, off}; axi_awlen = 8'd0;
        axi_wdata = d; axi_wstrb = s; axi_wlast = 1'b1; axi_wvalid = 1'b1;
        if (lead > 0) begin
            @(posedge clk); #1;
            axi_wvalid = 1'b0;
            repeat (lead - 1) begin
                chk("wait_aw_awready", 64'(axi_awready), 64'd1);
                chk("wait_aw_wready", 64'(axi_wready), 64'd0);
                @(posedge clk); #1;
            end
        end
        axi_awvalid = 1'b1;
        @(posedge clk); #1;
        axi_awvalid = 1'b0; axi_wvalid = 1'b0;
        tid++;
    endtask

    task automatic rd(input logic [15:0] off, input logic [7:0] len, input logic [63:0] d,
                      input logic [1:0] resp);
        int n = 0;
        r_t e;
        while (!axi_arready && n < 20) begin
            @(posedge clk); #1; n++;
        end
        if (n == 20) timeout("rd_ready");
        for (int i = 0; i <= int'(len); i++) begin
            e.id   = tid;
            e.data = len == 8'd0 ? d : 64'd0;
            e.resp = len == 8'd0 ? resp : RESP_SLVERR;
            e.last = i == int'(len);
            rq.push_back(e);
        end
        axi_arid = tid; axi_araddr = {48'hA5A5_0000_0000, off}; axi_arlen = len; axi_arvalid = 1'b1;
        @(posedge clk); #1;
        axi_arvalid = 1'b0;
        tid++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic [1:0] msip_resp;
        logic [63:0] msip_rd;
        logic msip_irq;
`ifdef CLINT_MSIP_EN
        msip_resp = RESP_OKAY; msip_rd = 64'd1; msip_irq = 1'b1;
`else
        msip_resp = RESP_DECERR; msip_rd = 64'd0; msip_irq = 1'b0;
`endif
        #12;
        chk("rst_time", time_o, 64'd0);
        chk("rst_irq", 64'(time_irq_o), 64'd0);
        chk("rst_soft", 64'(soft_irq_o), 64'd0);
        chk("rst_ready", 64'({axi_awready, axi_wready, axi_arready}), 64'h7);
        chk("rst_valid", 64'({axi_bvalid, axi_rvalid}), 64'h0);
        rstn = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        chk("idle_10_time", time_o, 64'd10);
        chk("idle_10_irq", 64'(time_irq_o), 64'd0);

        wr(CLINT_MTIMECMP_OFF, 64'h20, 8'hFF, RESP_OKAY, 0);
        chk("b_latency", 64'(axi_bvalid), 64'd1);
        n = 0;
        while (time_o != 64'h20 && n < 64) begin
            @(posedge clk); #1; n++;
        end
        if (n == 64) timeout("mtime_reach_20");
        chk("irq_at_eq", 64'(time_irq_o), 64'd0);
        @(posedge clk); #1;
        chk("irq_rise", 64'(time_irq_o), 64'd1);
        wr(CLINT_MTIMECMP_OFF, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, RESP_OKAY, 0);
        chk("irq_hold", 64'(time_irq_o), 64'd1);
        @(posedge clk); #1;
        chk("irq_fall", 64'(time_irq_o), 64'd0);

        wr(CLINT_MTIME_OFF, 64'h1234_5678_0000_0000, 8'hFF, RESP_OKAY, 3);
        rd(CLINT_MTIME_OFF, 8'd0, 64'h1234_5678_0000_0000, RESP_OKAY);
        rd(CLINT_MTIME_OFF, 8'd0, 64'h1234_5678_0000_0002, RESP_OKAY);

        wr(CLINT_MTIME_OFF, 64'h0000_0001_FFFF_FFFE, 8'hFF, RESP_OKAY, 0);
        wr(CLINT_MTIME_OFF, 64'd0, 8'h0F, RESP_OKAY, 0);
        rd(CLINT_MTIME_OFF, 8'd0, 64'h0000_0002_0000_0000, RESP_OKAY);

        rd(16'h8000, 8'd0, 64'd0, RESP_DECERR);
        rd(CLINT_MTIME_OFF, 8'd3, 64'd0, RESP_SLVERR);

        axi_bready = 1'b0;
        wr(16'h8000, 64'h55, 8'hFF, RESP_DECERR, 0);
        repeat (5) begin
            chk("bstall_valid", 64'(axi_bvalid), 64'd1);
            chk("bstall_resp", 64'(axi_bresp), 64'(RESP_DECERR));
            @(posedge clk); #1;
        end
        axi_bready = 1'b1;

        n = 0;
        while (!(axi_awready && axi_wready) && n < 20) begin
            @(posedge clk); #1; n++;
        end
        if (n == 20) timeout("burst_wr_ready");
        bq.push_back('{id: tid, resp: RESP_SLVERR});
        axi_awid = tid; axi_awaddr = {48'hA5A5_0000_0000, CLINT_MTIMECMP_OFF}; axi_awlen = 8'd1;
        axi_awvalid = 1'b1; axi_wdata = 64'h55; axi_wstrb = 8'hFF; axi_wlast = 1'b0; axi_wvalid = 1'b1;
        @(posedge clk); #1;
        axi_awvalid = 1'b0; axi_wlast = 1'b1;
        @(posedge clk); #1;
        axi_wvalid = 1'b0; axi_awlen = 8'd0;
        tid++;
        rd(CLINT_MTIMECMP_OFF, 8'd0, 64'hFFFF_FFFF_FFFF_FFFF, RESP_OKAY);

        wr(CLINT_MSIP_OFF, 64'd1, 8'h01, msip_resp, 0);
        chk("soft_at_write", 64'(soft_irq_o), 64'd0);
        @(posedge clk); #1;
        chk("soft_after", 64'(soft_irq_o), 64'(msip_irq));
        rd(CLINT_MSIP_OFF, 8'd0, msip_rd, msip_resp);

        n = 0;
        while ((bq.size() != 0 || rq.size() != 0) && n < 50) begin
            @(posedge clk); #1; n++;
        end
        if (n == 50) timeout("drain");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
